// File: rtl/plic_arbiter.sv
// Platform-level interrupt controller: per-source gateways, priority arbitration, claim/complete handshake.
// Latency: source edge -> pending 1 cycle, pending -> irq_o 1 cycle; claim_req -> claim_valid/claim_id 1 cycle.
// Backpressure: none; every claim, complete and config write is accepted in the cycle it is presented.
module plic_arbiter #(
  parameter int N_SRC  = 8,
  parameter int PRIO_W = 3,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 4
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic [N_SRC-1:0]  src_i,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [15:0]       cfg_wdata,
  input  logic              claim_req,
  output logic              claim_valid,
  output logic [ID_W-1:0]   claim_id,
  input  logic              complete_req,
  input  logic [ID_W-1:0]   complete_id,
  output logic              irq_o
);

  logic [PRIO_W-1:0] prio [N_SRC];
  logic [N_SRC-1:0]  enable;
  logic [PRIO_W-1:0] threshold;

  // Gateway state is one-hot per source: pending and inflight are never both set.
  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  inflight;

  logic [N_SRC-1:0]  eligible;
  logic [N_SRC-1:0]  win_onehot;
  logic [ID_W-1:0]   win_id;
  logic [PRIO_W-1:0] win_prio;
  logic [N_SRC-1:0]  claim_set;
  logic [N_SRC-1:0]  done_clr;
  logic [N_SRC-1:0]  pend_set;

  // Only the low bits of the write data carry configuration.
  logic cfg_wdata_unused;
  assign cfg_wdata_unused = ^cfg_wdata;

  // Eligibility: pending, enabled and strictly above the threshold.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_SRC; i++) begin
      eligible[i] = pending[i] & enable[i] & (prio[i] > threshold);
    end
  end

  // Highest priority wins; strict compare keeps the lowest index on ties.
  always_comb begin
    win_onehot = '0;
    win_id     = '0;
    win_prio   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (eligible[i] && (prio[i] > win_prio)) begin
        win_prio   = prio[i];
        win_id     = ID_W'(i + 1);
        win_onehot = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Gateway transitions; a completing source may re-pend at the same edge if its request is still high.
  always_comb begin
    claim_set = claim_req ? win_onehot : '0;
    done_clr  = '0;
    pend_set  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      done_clr[i] = complete_req && (complete_id == ID_W'(i + 1)) && inflight[i];
      pend_set[i] = src_i[i] && !pending[i] && (!inflight[i] || done_clr[i]);
    end
  end

  // Gateway state registers.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      pending  <= '0;
      inflight <= '0;
    end else begin
      pending  <= (pending & ~claim_set) | pend_set;
      inflight <= (inflight & ~done_clr) | claim_set;
    end
  end

  // Config registers; writes land at the edge, so a same-cycle claim sees old values.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < N_SRC; i++) prio[i] <= '0;
      enable    <= '0;
      threshold <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (cfg_addr == ADDR_W'(i)) prio[i] <= cfg_wdata[PRIO_W-1:0];
      end
      if (cfg_addr == ADDR_W'(N_SRC))     enable    <= cfg_wdata[N_SRC-1:0];
      if (cfg_addr == ADDR_W'(N_SRC + 1)) threshold <= cfg_wdata[PRIO_W-1:0];
    end
  end

  // CPU-facing outputs: registered irq, one-cycle claim response, sticky claim_id.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      irq_o       <= 1'b0;
      claim_valid <= 1'b0;
      claim_id    <= '0;
    end else begin
      irq_o       <= |eligible;
      claim_valid <= claim_req;
      if (claim_req) claim_id <= win_id;
    end
  end

endmodule
